led_out_pio: RTL and testbench
==============================

Name: led_out_pio

Overview:
- Avalon-MM slave output port that drives the board LEDs (WIDTH bits). It is the write-direction counterpart of the 6-bit edge-capture input PIO.
- CPU writes a data register directly, or uses atomic bit-set/bit-clear addresses.
- A per-bit hardware blink engine, a programmable half-period counter, gates selected bits without CPU load.
- Sits on the system Avalon bus beside the input PIO; out_port goes straight to the LED pins.

Parameters:
- WIDTH, 6, number of output bits (1..32).
- PERIOD_W, 24, width of the blink half-period register and counter (1..32).
- RESET_VALUE, 0, reset value of the DATA register (WIDTH bits).

Ports:
- clk  input  1  system clock.
- reset_n  input  1  asynchronous active-low reset.
- address  input  3  register word address.
- chipselect  input  1  slave select.
- write_n  input  1  active-low write strobe.
- writedata  input  32  write data; bits above WIDTH (or PERIOD_W) are ignored.
- readdata  output  32  registered read data.
- out_port  output  WIDTH  registered LED drive.

Behaviour:
- Reset: one clock, clk. Reset is asynchronous and active-low on reset_n.
  - Reset values: data=RESET_VALUE, blink_en=0, period=0, cnt=0, phase=0, readdata=0, out_port=RESET_VALUE.
- Write strobe: wr = chipselect && !write_n. The write takes effect on the clk edge where wr=1. No wait states; every access completes in 1 cycle.
- Register map (word addresses):
  - 0 DATA: R/W. data <= writedata[WIDTH-1:0].
  - 1 BLINK_EN: R/W per-bit blink mask.
  - 2 PERIOD: R/W blink half-period in clk cycles. A write also clears cnt to 0; phase is unchanged.
  - 3 STATUS: read returns {31'b0, phase}. A write of any value clears cnt and phase to 0.
  - 4 OUTSET: write only; data <= data | writedata[WIDTH-1:0]. Reads 0.
  - 5 OUTCLEAR: write only; data <= data & ~writedata[WIDTH-1:0]. Reads 0.
  - 6, 7: reserved; writes are ignored and reads return 0.
- Read path:
  - readdata <= zero-extended mux(address) on every clk edge, independent of chipselect.
  - Read latency is 1 cycle: the value seen is the register contents before any write on the same edge.
- Blink timer:
  - If period==0: cnt holds at 0 and phase holds.
  - Else, each cycle: if cnt==period-1 then cnt<=0 and phase<=~phase; otherwise cnt<=cnt+1.
  - period=1 toggles phase every cycle. Counter wrap is at period-1; it never overflows PERIOD_W.
  - Simultaneous PERIOD or STATUS write and terminal count: the write wins (cnt=0). For STATUS, phase is also 0. For PERIOD, phase is not toggled.
- Output:
  - out_port <= data & ~(blink_en & {WIDTH{phase}}), registered.
  - A DATA write on edge N appears on out_port after edge N+1.
  - Blink-enabled bits are forced off while phase=1.
- Reset mid-operation: all state returns to reset values immediately (asynchronously). out_port returns to RESET_VALUE without waiting for a clock edge.

Decomposition:
- Shared package led_pio_pkg holds:
  - register address constants ADDR_DATA=0, ADDR_BLINK_EN=1, ADDR_PERIOD=2, ADDR_STATUS=3, ADDR_OUTSET=4, ADDR_OUTCLEAR=5;
  - STATUS bit index STAT_PHASE=0.
- One sub-module, led_blink_timer.
  - Ports: clk, reset_n, period, period_wr, restart; outputs phase.
  - Contains cnt and phase. The top module holds the registers, the read mux and the output register.

Test Plan:
1. Reset and reads: assert reset_n=0 mid-cycle; out_port drops to 0 at once. Read addresses 0..7 -> readdata 0 at every address, each value valid one cycle after the address.
2. Atomic set/clear: write DATA=0x2A, then OUTSET=0x05, then OUTCLEAR=0x28 -> DATA reads 0x2A, 0x2F, 0x07 in turn. out_port follows each value one cycle after the write edge.
3. Blink: DATA=0x3F, BLINK_EN=0x03, PERIOD=4 -> phase toggles every 4 cycles; out_port alternates 0x3F/0x3C with a 4-cycle dwell. STATUS bit0 tracks phase.
4. Edge cases:
   - PERIOD=1 -> out_port alternates every cycle.
   - PERIOD=0 written while phase=1 -> phase frozen at 1; out_port stays at 0x3C.
   - STATUS write -> phase=0; out_port=0x3F.
5. Collision: a PERIOD write lands on the terminal-count cycle -> no toggle; cnt restarts from 0; the next toggle comes exactly period cycles later.
6. Ignored traffic:
   - Write with chipselect=0 -> no register change.
   - Writes to addresses 6 and 7 -> no change.
   - writedata=0xFFFFFFC0 to DATA -> DATA=0x00 (upper bits ignored).

Source files
------------

// File: rtl/led_pio_pkg.sv
// Shared definitions for the LED output PIO.
// Holds the register word addresses, the STATUS bit layout and a helper
// that packs the STATUS read word.
package led_pio_pkg;

  localparam logic [2:0] ADDR_DATA     = 3'd0;
  localparam logic [2:0] ADDR_BLINK_EN = 3'd1;
  localparam logic [2:0] ADDR_PERIOD   = 3'd2;
  localparam logic [2:0] ADDR_STATUS   = 3'd3;
  localparam logic [2:0] ADDR_OUTSET   = 3'd4;
  localparam logic [2:0] ADDR_OUTCLEAR = 3'd5;

  localparam int STAT_PHASE = 0;

  // Build the 32-bit STATUS read word from the current blink phase.
  function automatic logic [31:0] status_word(input logic phase);
    logic [31:0] w;
    w = 32'h0000_0000;
    w[STAT_PHASE] = phase;
    return w;
  endfunction

endpackage

// File: rtl/led_out_pio_if.sv
// Avalon-MM slave bus bundle for the LED output PIO.
// Signals: address (word address), chipselect, write_n (active-low write),
// writedata (32 bit), readdata (32 bit, registered in the slave).
interface led_out_pio_if;

  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );

endinterface

// File: rtl/led_blink_timer.sv
// Blink half-period timer for the LED output PIO.
// Ports:
//   clk, reset_n  - clock, asynchronous active-low reset
//   period        - half-period in clk cycles (0 freezes the timer)
//   period_wr     - PERIOD register write this cycle: restart count, keep phase
//   restart       - STATUS register write this cycle: restart count, phase to 0
//   phase         - registered blink phase
module led_blink_timer #(
  parameter int PERIOD_W = 24
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [PERIOD_W-1:0] period,
  input  logic                period_wr,
  input  logic                restart,
  output logic                phase
);

  logic [PERIOD_W-1:0] cnt_q;
  logic [PERIOD_W-1:0] cnt_d;
  logic                phase_q;
  logic                phase_d;

  // Next count/phase; register writes take priority over a terminal count.
  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (restart) begin
      cnt_d   = {PERIOD_W{1'b0}};
      phase_d = 1'b0;
    end else if (period_wr) begin
      cnt_d   = {PERIOD_W{1'b0}};
    end else if (period == {PERIOD_W{1'b0}}) begin
      cnt_d   = {PERIOD_W{1'b0}};
    end else if (cnt_q == (period - {{(PERIOD_W-1){1'b0}}, 1'b1})) begin
      // Wrap at period-1 so the counter never exceeds the register width.
      cnt_d   = {PERIOD_W{1'b0}};
      phase_d = ~phase_q;
    end else begin
      cnt_d   = cnt_q + {{(PERIOD_W-1){1'b0}}, 1'b1};
    end
  end

  // Count and phase state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q   <= {PERIOD_W{1'b0}};
      phase_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  assign phase = phase_q;

endmodule

// File: rtl/led_out_pio.sv
// LED output PIO: Avalon-MM slave with DATA, atomic set/clear and a
// per-bit hardware blink mask.
// Ports:
//   clk, reset_n - clock, asynchronous active-low reset
//   bus          - Avalon-MM slave (address, chipselect, write_n,
//                  writedata, registered readdata with 1-cycle latency)
//   out_port     - registered LED drive, WIDTH bits
module led_out_pio
  import led_pio_pkg::*;
#(
  parameter int               WIDTH       = 6,
  parameter int               PERIOD_W    = 24,
  parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
  input  logic              clk,
  input  logic              reset_n,
  led_out_pio_if.slave      bus,
  output logic [WIDTH-1:0]  out_port
);

  logic                wr_s;
  logic                period_wr_s;
  logic                restart_s;
  logic                phase_s;
  logic                unused_wdata_s;

  logic [WIDTH-1:0]    data_q;
  logic [WIDTH-1:0]    data_d;
  logic [WIDTH-1:0]    blink_en_q;
  logic [WIDTH-1:0]    blink_en_d;
  logic [PERIOD_W-1:0] period_q;
  logic [PERIOD_W-1:0] period_d;
  logic [31:0]         readdata_q;
  logic [31:0]         readdata_d;
  logic [WIDTH-1:0]    out_q;
  logic [WIDTH-1:0]    out_d;

  assign wr_s        = bus.chipselect && !bus.write_n;
  assign period_wr_s = wr_s && (bus.address == ADDR_PERIOD);
  assign restart_s   = wr_s && (bus.address == ADDR_STATUS);

  // Upper writedata bits are architecturally ignored.
  assign unused_wdata_s = ^bus.writedata;

  led_blink_timer #(
    .PERIOD_W (PERIOD_W)
  ) u_timer (
    .clk       (clk),
    .reset_n   (reset_n),
    .period    (period_q),
    .period_wr (period_wr_s),
    .restart   (restart_s),
    .phase     (phase_s)
  );

  // Register write decode, including atomic set/clear of DATA.
  always_comb begin
    data_d     = data_q;
    blink_en_d = blink_en_q;
    period_d   = period_q;
    if (wr_s) begin
      case (bus.address)
        ADDR_DATA:     data_d     = bus.writedata[WIDTH-1:0];
        ADDR_BLINK_EN: blink_en_d = bus.writedata[WIDTH-1:0];
        ADDR_PERIOD:   period_d   = bus.writedata[PERIOD_W-1:0];
        ADDR_OUTSET:   data_d     = data_q | bus.writedata[WIDTH-1:0];
        ADDR_OUTCLEAR: data_d     = data_q & ~bus.writedata[WIDTH-1:0];
        default:       data_d     = data_q;
      endcase
    end else begin
      data_d = data_q;
    end
  end

  // Read mux over the pre-write register contents, independent of chipselect.
  always_comb begin
    readdata_d = 32'h0000_0000;
    case (bus.address)
      ADDR_DATA:     readdata_d[WIDTH-1:0]    = data_q;
      ADDR_BLINK_EN: readdata_d[WIDTH-1:0]    = blink_en_q;
      ADDR_PERIOD:   readdata_d[PERIOD_W-1:0] = period_q;
      ADDR_STATUS:   readdata_d               = status_word(phase_s);
      default:       readdata_d               = 32'h0000_0000;
    endcase
  end

  // Blink-enabled bits are forced off while phase is high.
  always_comb begin
    out_d = data_q & ~(blink_en_q & {WIDTH{phase_s}});
  end

  // Register file, read data and LED output register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q     <= RESET_VALUE;
      blink_en_q <= {WIDTH{1'b0}};
      period_q   <= {PERIOD_W{1'b0}};
      readdata_q <= 32'h0000_0000;
      out_q      <= RESET_VALUE;
    end else begin
      data_q     <= data_d;
      blink_en_q <= blink_en_d;
      period_q   <= period_d;
      readdata_q <= readdata_d;
      out_q      <= out_d;
    end
  end

  assign bus.readdata = readdata_q;
  assign out_port     = out_q;

endmodule

// File: tb/tb_led_out_pio.sv
// Self-checking bench for led_out_pio: directed scenarios followed by random
// bus traffic, every cycle compared against a behavioural model that derives
// the blink phase arithmetically from the last restart point.
module tb_led_out_pio;
  import led_pio_pkg::*;

  localparam int WIDTH    = 6;
  localparam int PERIOD_W = 24;
  localparam logic [31:0] DMASK = 32'h0000_003F;
  localparam logic [31:0] PMASK = 32'h00FF_FFFF;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [WIDTH-1:0] out_port;

  always #5 clk = ~clk;

  led_out_pio_if bus_if ();

  led_out_pio #(
    .WIDTH       (WIDTH),
    .PERIOD_W    (PERIOD_W),
    .RESET_VALUE (6'h00)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .bus      (bus_if.slave),
    .out_port (out_port)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state.
  logic [31:0] m_data;
  logic [31:0] m_blink;
  longint      m_per;
  longint      m_t0;   // edge after which the count was last zeroed
  longint      m_e;    // edges since reset release
  bit          m_ph0;  // phase at m_t0

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %h expected %h (edge %0d)", tag, obs, exp, m_e);
    end
  endtask

  // Phase after edge t: one toggle per full half-period since the anchor.
  function automatic bit m_phase(input longint t);
    if (m_per == 0) return m_ph0;
    return m_ph0 ^ bit'(((t - m_t0) / m_per) % 2);
  endfunction

  task automatic model_reset();
    m_data  = 32'h0;
    m_blink = 32'h0;
    m_per   = 0;
    m_t0    = 0;
    m_e     = 0;
    m_ph0   = 1'b0;
  endtask

  // One bus cycle with full readdata/out_port check one edge later.
  task automatic step(input bit cs, input bit wn, input logic [2:0] a, input logic [31:0] wd);
    logic [31:0] exp_rd;
    logic [31:0] exp_out;
    bit          ph;
    @(negedge clk);
    bus_if.chipselect = cs;
    bus_if.write_n    = wn;
    bus_if.address    = a;
    bus_if.writedata  = wd;
    ph = m_phase(m_e);
    case (a)
      3'd0:    exp_rd = m_data;
      3'd1:    exp_rd = m_blink;
      3'd2:    exp_rd = 32'(m_per);
      3'd3:    exp_rd = {31'b0, ph};
      default: exp_rd = 32'h0;
    endcase
    exp_out = m_data & ~(m_blink & (ph ? DMASK : 32'h0));
    @(posedge clk);
    if (cs && !wn) begin
      case (a)
        3'd0: m_data  = wd & DMASK;
        3'd1: m_blink = wd & DMASK;
        3'd2: begin m_ph0 = ph;   m_t0 = m_e + 1; m_per = longint'(wd & PMASK); end
        3'd3: begin m_ph0 = 1'b0; m_t0 = m_e + 1; end
        3'd4: m_data = m_data | (wd & DMASK);
        3'd5: m_data = m_data & ~(wd & DMASK);
        default: ;
      endcase
    end
    m_e++;
    #1;
    check_eq("readdata", bus_if.readdata, exp_rd);
    check_eq("out_port", {26'b0, out_port}, exp_out);
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] wd);
    step(1'b1, 1'b0, a, wd);
  endtask

  task automatic rd(input logic [2:0] a);
    step(1'b1, 1'b1, a, 32'h0);
  endtask

  initial begin
    logic [2:0]  ra;
    logic [31:0] rw;
    bus_if.chipselect = 1'b0;
    bus_if.write_n    = 1'b1;
    bus_if.address    = 3'd0;
    bus_if.writedata  = 32'h0;
    reset_n = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_out", {26'b0, out_port}, 32'h0);
    check_eq("reset_rd", bus_if.readdata, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;

    // Mid-cycle asynchronous reset with LEDs lit.
    wr(ADDR_DATA, 32'h15);
    rd(ADDR_DATA);
    #2 reset_n = 1'b0;
    #1;
    check_eq("async_rst_out", {26'b0, out_port}, 32'h0);
    check_eq("async_rst_rd", bus_if.readdata, 32'h0);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;

    // Every address reads zero after reset.
    for (int i = 0; i < 8; i++) rd(3'(i));
    rd(3'd0);

    // Atomic set / clear.
    wr(ADDR_DATA, 32'h2A);
    rd(ADDR_DATA);
    wr(ADDR_OUTSET, 32'h05);
    rd(ADDR_DATA);
    wr(ADDR_OUTCLEAR, 32'h28);
    rd(ADDR_DATA);
    rd(ADDR_OUTSET);
    rd(ADDR_OUTCLEAR);

    // Blink with half-period 4.
    wr(ADDR_DATA, 32'h3F);
    wr(ADDR_BLINK_EN, 32'h03);
    wr(ADDR_PERIOD, 32'h4);
    for (int i = 0; i < 20; i++) rd(ADDR_STATUS);

    // Half-period 1, then freeze with phase high.
    wr(ADDR_PERIOD, 32'h1);
    for (int i = 0; i < 4; i++) rd(ADDR_STATUS);
    for (int i = 0; i < 4 && !m_phase(m_e); i++) rd(ADDR_STATUS);
    wr(ADDR_PERIOD, 32'h0);
    for (int i = 0; i < 6; i++) rd(ADDR_STATUS);
    check_eq("frozen_phase", {26'b0, out_port}, 32'h3C);

    // STATUS write clears phase.
    wr(ADDR_STATUS, 32'hFFFF_FFFF);
    for (int i = 0; i < 3; i++) rd(ADDR_STATUS);
    check_eq("status_clear", {26'b0, out_port}, 32'h3F);

    // PERIOD write colliding with the terminal count.
    wr(ADDR_PERIOD, 32'h4);
    for (int i = 0; i < 10 && ((m_e - m_t0) % m_per) != (m_per - 1); i++) rd(ADDR_STATUS);
    wr(ADDR_PERIOD, 32'h4);
    for (int i = 0; i < 12; i++) rd(ADDR_STATUS);

    // Ignored traffic.
    step(1'b0, 1'b0, ADDR_DATA, 32'h11);
    rd(ADDR_DATA);
    wr(3'd6, 32'hFFFF_FFFF);
    wr(3'd7, 32'hFFFF_FFFF);
    rd(ADDR_DATA);
    rd(ADDR_BLINK_EN);
    wr(ADDR_DATA, 32'hFFFF_FFC0);
    rd(ADDR_DATA);
    rd(ADDR_DATA);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      ra = 3'($urandom_range(0, 7));
      rw = $urandom;
      if (ra == ADDR_PERIOD) rw = (rw & 32'hFF00_0000) | 32'($urandom_range(0, 6));
      if (ra == ADDR_STATUS && $urandom_range(0, 3) != 0) ra = ADDR_DATA;
      step(bit'($urandom_range(0, 3) != 0), bit'($urandom_range(0, 1)), ra, rw);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
